// File: rtl/br_pred_queue_pkg.sv
// Shared branch-queue constants and the per-entry status record.
package br_pred_queue_pkg;

  localparam int unsigned AddrWidth      = 32;
  localparam int unsigned PredQueueDepth = 8;
  localparam logic        BrTaken        = 1'b1;

  // The PC and valid bit are kept beside the record: the PC width is a module parameter, and
  // valid is the only per-entry field that reset clears.
  typedef struct packed {
    logic pred;
    logic resolved;
    logic taken;
  } br_queue_entry_t;

  function automatic logic is_mispredict(input br_queue_entry_t e);
    return (e.pred == BrTaken) != (e.taken == BrTaken);
  endfunction

endpackage

// File: rtl/br_pred_queue.sv
// In-order branch prediction queue: push at fetch, resolve out of order, retire and commit in
// order to the counter table.
module br_pred_queue
  import br_pred_queue_pkg::*;
#(
  parameter int unsigned ADDR  = AddrWidth,
  parameter int unsigned DEPTH = PredQueueDepth,
  parameter int unsigned PTR   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_,
  input  logic            br_push_,
  input  logic [ADDR-1:0] br_pc,
  input  logic            br_pred,
  output logic [PTR-1:0]  br_tag,
  output logic            br_full,
  output logic            br_empty,
  input  logic            br_exe_,
  input  logic [PTR-1:0]  br_exe_tag,
  input  logic            br_exe_taken,
  input  logic            br_retire_,
  output logic            retire_rdy,
  output logic [ADDR-1:0] commit_pc,
  output logic            br_commit_,
  output logic            br_result,
  output logic            br_pred_miss_
);

  localparam logic [PTR:0]   FullCount = (PTR+1)'(DEPTH);
  localparam logic [PTR-1:0] PtrOne    = PTR'(1);
  localparam logic [PTR:0]   CountOne  = (PTR+1)'(1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR-1:0]   head_q, head_d;
  logic [PTR-1:0]   tail_q, tail_d;
  logic [PTR:0]     count_q, count_d;
  logic [ADDR-1:0]  pc_q [DEPTH];
  br_queue_entry_t  meta_q [DEPTH];
  br_queue_entry_t  head_meta;

  logic            push_en, resolve_en, retire_en;
  logic [ADDR-1:0] commit_pc_q;
  logic            commit_n_q, result_q, miss_n_q;

  assign br_tag     = tail_q;
  assign br_full    = (count_q == FullCount);
  assign br_empty   = (count_q == '0);
  assign head_meta  = meta_q[head_q];
  assign retire_rdy = valid_q[head_q] & head_meta.resolved;

  assign push_en    = flush_ & ~br_push_ & ~br_full;
  assign retire_en  = flush_ & ~br_retire_ & retire_rdy;
  // The slot being pushed is not yet valid, so a resolve aimed at it is dropped.
  assign resolve_en = flush_ & ~br_exe_ & valid_q[br_exe_tag] &
                      ~(push_en & (br_exe_tag == tail_q));

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (!flush_) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + PtrOne;
      end
      if (retire_en) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PtrOne;
      end
      unique case ({push_en, retire_en})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is meaningless while valid is clear, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_q[tail_q]   <= br_pc;
      meta_q[tail_q] <= '{pred: br_pred, resolved: 1'b0, taken: 1'b0};
    end
    if (resolve_en) begin
      meta_q[br_exe_tag].resolved <= 1'b1;
      meta_q[br_exe_tag].taken    <= br_exe_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_n_q  <= 1'b1;
      miss_n_q    <= 1'b1;
      commit_pc_q <= '0;
      result_q    <= 1'b0;
    end else begin
      commit_n_q <= ~retire_en;
      miss_n_q   <= ~(retire_en & is_mispredict(head_meta));
      if (retire_en) begin
        commit_pc_q <= pc_q[head_q];
        result_q    <= head_meta.taken;
      end
    end
  end

  assign commit_pc     = commit_pc_q;
  assign br_commit_    = commit_n_q;
  assign br_result     = result_q;
  assign br_pred_miss_ = miss_n_q;

endmodule

// File: tb/tb_br_pred_queue.sv
// Directed bench for br_pred_queue with a queue-based reference model checked every cycle.
module tb_br_pred_queue;

  localparam int DEPTH = 8;

  logic        clk, reset, flush_, br_push_, br_pred, br_exe_, br_exe_taken, br_retire_;
  logic [31:0] br_pc;
  logic [2:0]  br_exe_tag;
  logic [2:0]  br_tag;
  logic        br_full, br_empty, retire_rdy, br_commit_, br_result, br_pred_miss_;
  logic [31:0] commit_pc;

  br_pred_queue dut (
    .clk          (clk),
    .reset        (reset),
    .flush_       (flush_),
    .br_push_     (br_push_),
    .br_pc        (br_pc),
    .br_pred      (br_pred),
    .br_tag       (br_tag),
    .br_full      (br_full),
    .br_empty     (br_empty),
    .br_exe_      (br_exe_),
    .br_exe_tag   (br_exe_tag),
    .br_exe_taken (br_exe_taken),
    .br_retire_   (br_retire_),
    .retire_rdy   (retire_rdy),
    .commit_pc    (commit_pc),
    .br_commit_   (br_commit_),
    .br_result    (br_result),
    .br_pred_miss_(br_pred_miss_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of in-flight branches, oldest first, each tagged at push time.
  typedef struct {
    int          tag;
    logic [31:0] pc;
    bit          pred;
    bit          res;
    bit          taken;
  } ment_t;

  ment_t       mq[$];
  int          ntag     = 0;
  bit          live     = 0;
  bit          m_commit_n = 1, m_miss_n = 1, m_result = 0;
  logic [31:0] m_pc     = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      ntag = 0; live = 1;
      m_commit_n = 1; m_miss_n = 1; m_pc = 0; m_result = 0;
    end else if (live) begin
      m_commit_n = 1; m_miss_n = 1;
      if (!flush_) begin
        mq.delete();
        ntag = 0;
      end else begin
        bit rdy, full;
        ment_t h;
        rdy  = (mq.size() > 0) && mq[0].res;
        full = (mq.size() == DEPTH);
        if (!br_retire_ && rdy) begin
          h = mq.pop_front();
          m_commit_n = 0;
          m_pc       = h.pc;
          m_result   = h.taken;
          m_miss_n   = (h.pred == h.taken);
        end
        if (!br_exe_) begin
          for (int k = 0; k < mq.size(); k++)
            if (mq[k].tag == int'(br_exe_tag)) begin
              mq[k].res   = 1;
              mq[k].taken = br_exe_taken;
            end
        end
        if (!br_push_ && !full) begin
          mq.push_back('{tag: ntag, pc: br_pc, pred: br_pred, res: 0, taken: 0});
          ntag = (ntag + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("br_tag", 32'(br_tag), 32'(ntag));
      chk("br_full", 32'(br_full), 32'(mq.size() == DEPTH));
      chk("br_empty", 32'(br_empty), 32'(mq.size() == 0));
      chk("retire_rdy", 32'(retire_rdy), 32'((mq.size() > 0) && mq[0].res));
      chk("br_commit_", 32'(br_commit_), 32'(m_commit_n));
      chk("br_pred_miss_", 32'(br_pred_miss_), 32'(m_miss_n));
      chk("commit_pc", commit_pc, m_pc);
      chk("br_result", 32'(br_result), 32'(m_result));
    end
  end

  task automatic idle();
    flush_ = 1; br_push_ = 1; br_exe_ = 1; br_retire_ = 1;
    br_pc = '0; br_pred = 0; br_exe_tag = '0; br_exe_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pred);
    br_push_ = 0; br_pc = pc; br_pred = pred;
  endtask

  task automatic set_resolve(input int tag, input logic taken);
    br_exe_ = 0; br_exe_tag = 3'(tag); br_exe_taken = taken;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    reset = 0;
    chk("rst empty", 32'(br_empty), 32'd1);
    chk("rst tag", 32'(br_tag), 32'd0);
    chk("rst commit_", 32'(br_commit_), 32'd1);
    chk("rst commit_pc", commit_pc, 32'h0);

    // Three pushes, resolve all taken, retire: misses on the not-taken prediction only.
    set_push(32'h100, 1); step();
    set_push(32'h104, 0); step();
    set_push(32'h108, 1); step();
    idle();
    chk("tag after 3", 32'(br_tag), 32'd3);
    for (int t = 0; t < 3; t++) begin
      set_resolve(t, 1); step();
    end
    idle();
    br_retire_ = 0;
    step();
    chk("c0 commit_", 32'(br_commit_), 32'd0);
    chk("c0 pc", commit_pc, 32'h100);
    chk("c0 miss_", 32'(br_pred_miss_), 32'd1);
    step();
    chk("c1 pc", commit_pc, 32'h104);
    chk("c1 miss_", 32'(br_pred_miss_), 32'd0);
    chk("c1 result", 32'(br_result), 32'd1);
    step();
    chk("c2 pc", commit_pc, 32'h108);
    chk("c2 miss_", 32'(br_pred_miss_), 32'd1);
    idle();
    step();
    chk("hold commit_", 32'(br_commit_), 32'd1);
    chk("hold pc", commit_pc, 32'h108);

    // Fill to full, overflow push dropped, push+retire while full still drops the push.
    for (int i = 0; i < 8; i++) begin
      set_push(32'h200 + 32'(4 * i), 1); step();
    end
    chk("full", 32'(br_full), 32'd1);
    chk("full tag", 32'(br_tag), 32'd3);
    set_push(32'h300, 0); step();
    chk("9th dropped tag", 32'(br_tag), 32'd3);
    idle();
    set_resolve(3, 0); step();
    idle();
    set_push(32'h304, 0); br_retire_ = 0; step();
    idle();
    chk("pr full", 32'(br_full), 32'd0);
    chk("pr commit_", 32'(br_commit_), 32'd0);
    chk("pr pc", commit_pc, 32'h200);
    chk("pr tag", 32'(br_tag), 32'd3);
    chk("pr miss_", 32'(br_pred_miss_), 32'd0);
    set_push(32'h308, 1); step();
    idle();
    chk("refull", 32'(br_full), 32'd1);
    flush_ = 0; step();
    idle();
    chk("flushed empty", 32'(br_empty), 32'd1);

    // Out-of-order resolve: head unresolved blocks retire.
    set_push(32'h500, 0); step();
    set_push(32'h504, 1); step();
    idle();
    set_resolve(1, 1); step();
    idle();
    br_retire_ = 0; step();
    chk("blocked rdy", 32'(retire_rdy), 32'd0);
    chk("blocked commit_", 32'(br_commit_), 32'd1);
    set_resolve(0, 0); step();
    chk("rdy after res", 32'(retire_rdy), 32'd1);
    chk("no commit yet", 32'(br_commit_), 32'd1);
    br_exe_ = 1; step();
    chk("e0 commit_", 32'(br_commit_), 32'd0);
    chk("e0 pc", commit_pc, 32'h500);
    chk("e0 result", 32'(br_result), 32'd0);
    step();
    idle();
    chk("e1 pc", commit_pc, 32'h504);

    // Fill 5 (first with a same-cycle resolve to its own slot), then flush with retire.
    set_push(32'h600, 1); set_resolve(2, 1); step();
    idle();
    for (int i = 1; i < 5; i++) begin
      set_push(32'h600 + 32'(4 * i), 1); step();
    end
    idle();
    chk("self-res ignored", 32'(retire_rdy), 32'd0);
    set_resolve(2, 1); step();
    idle();
    chk("head rdy", 32'(retire_rdy), 32'd1);
    flush_ = 0; br_retire_ = 0; step();
    idle();
    chk("flush empty", 32'(br_empty), 32'd1);
    chk("flush commit_", 32'(br_commit_), 32'd1);
    chk("flush tag", 32'(br_tag), 32'd0);

    // Streaming: push each cycle, resolve last push, retire when ready; pointers wrap.
    for (int i = 0; i < 20; i++) begin
      idle();
      set_push(32'h1000 + 32'(4 * i), 1'(i & 1));
      if (i > 0) set_resolve((i - 1) % DEPTH, 1'((i >> 1) & 1));
      br_retire_ = 0;
      step();
    end
    idle();
    br_retire_ = 0;
    set_resolve(19 % DEPTH, 1);
    step();
    br_exe_ = 1;
    for (int i = 0; i < 4; i++) step();
    idle();
    chk("stream drained", 32'(br_empty), 32'd1);
    chk("stream last pc", commit_pc, 32'h1000 + 32'(4 * 19));

    // Reset with entries in flight and a retire requested in the same cycle.
    for (int i = 0; i < 3; i++) begin
      set_push(32'h700 + 32'(4 * i), 0); step();
    end
    idle();
    set_resolve(20 % DEPTH, 1); step();
    idle();
    br_retire_ = 0; reset = 1; step();
    reset = 0; idle();
    chk("rst2 commit_", 32'(br_commit_), 32'd1);
    chk("rst2 empty", 32'(br_empty), 32'd1);
    chk("rst2 tag", 32'(br_tag), 32'd0);
    chk("rst2 pc", commit_pc, 32'h0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/br_pred_queue.md
BR_PRED_QUEUE -- requirements
Module: br_pred_queue

Interface
REQ-001 Parameters SHALL be:
- ADDR, default `AddrWidth, PC width.
- DEPTH, default `PredQueueDepth (8), entry count, power of two, 2 or more.
- PTR, fixed to $clog2(DEPTH), tag width.

REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_  in  1  active-low pipeline flush.
- br_push_  in  1  active-low push of a predicted branch from fetch.
- br_pc  in  ADDR  PC of the pushed branch.
- br_pred  in  1  predicted direction (`BrTaken = 1).
- br_tag  out  PTR  tag assigned to the next push (tail pointer).
- br_full  out  1  queue holds DEPTH entries.
- br_empty  out  1  queue holds 0 entries.
- br_exe_  in  1  active-low resolve strobe from the branch unit.
- br_exe_tag  in  PTR  entry being resolved.
- br_exe_taken  in  1  actual direction.
- br_retire_  in  1  active-low in-order retire request.
- retire_rdy  out  1  head entry is valid and resolved.
- commit_pc  out  ADDR  PC of the retired branch, to the counter table.
- br_commit_  out  1  active-low one-cycle commit pulse.
- br_result  out  1  actual direction of the retired branch.
- br_pred_miss_  out  1  active-low, low when the prediction was wrong.

Function
REQ-003 Each entry SHALL hold valid, pc, pred, resolved and taken.
REQ-004 A push SHALL be accepted only when br_push_=0 and the registered br_full=0; a push while full SHALL be dropped with no state change, even if a retire occurs in the same cycle.
REQ-005 An accepted push SHALL write the entry at tail with valid=1 and resolved=0, then advance tail by 1 modulo DEPTH.
REQ-006 br_tag, br_full and br_empty SHALL be combinational from registered state.
REQ-007 When br_exe_=0 and entry[br_exe_tag].valid=1, the block SHALL set resolved=1 and taken=br_exe_taken; a resolve to an invalid entry SHALL be ignored.
REQ-008 retire_rdy SHALL equal entry[head].valid AND entry[head].resolved, computed from registered state only, so a head resolved in cycle N is retirable no earlier than cycle N+1.
REQ-009 A retire SHALL be accepted only when br_retire_=0 and retire_rdy=1; when accepted, head.valid SHALL clear and head SHALL advance by 1 modulo DEPTH.
REQ-010 Commit outputs SHALL be registered with 1-cycle latency: the cycle after an accepted retire, br_commit_=0, commit_pc=pc, br_result=taken, and br_pred_miss_=0 if pred!=taken, else 1.
REQ-011 In every other cycle, br_commit_ and br_pred_miss_ SHALL be 1, and commit_pc and br_result SHALL hold their last values.
REQ-012 Occupancy count (0..DEPTH, PTR+1 bits) SHALL be: +1 on push only, -1 on retire only, unchanged on both or neither.
REQ-013 Push, resolve and retire to distinct entries SHALL all take effect in the same cycle.
REQ-014 A resolve to the entry being pushed in the same cycle SHALL be ignored.
REQ-015 On flush_=0, all valid bits, head, tail and count SHALL clear next cycle; flush SHALL override push, resolve and retire in that cycle, and br_commit_ SHALL be 1 the following cycle.
REQ-016 Pointers SHALL wrap silently; full and empty SHALL be distinguished by count, not by pointer equality.

Reset
REQ-017 With reset=1 at a clock edge: head=tail=count=0, all valid bits=0, br_commit_=1, br_pred_miss_=1, commit_pc=0, br_result=0.
REQ-018 Reset SHALL take priority over flush and all other inputs, including mid-operation with a retire pending.
REQ-019 Reset SHALL NOT clear entry payload (pc, pred, taken); payload is don't-care while valid=0.

Structure
REQ-020 `BrTaken and `PredQueueDepth SHALL live in the shared branch.svh and cpu_config.svh headers; the entry struct br_queue_entry_t SHALL live in the shared branch package.
REQ-021 The block SHALL be a single module with no sub-module; commit outputs connect directly to the counter table's commit_pc, br_commit_, br_result and br_pred_miss_.

Verification
REQ-022 Push PCs 0x100, 0x104, 0x108 with pred=1,0,1; resolve tags 0,1,2 as taken=1,1,1; retire three times -> commit_pc sequence 0x100, 0x104, 0x108 with br_pred_miss_ = 1, 0, 1.
REQ-023 Push 8 entries (DEPTH=8) -> br_full=1; a 9th push is dropped; push and retire in the same cycle while full -> push still dropped, count=7.
REQ-024 Push 2 entries, resolve tag 1 only, request retire -> retire_rdy=0 and no commit; then resolve tag 0 -> retire_rdy=1 the next cycle and commit of entry 0.
REQ-025 Fill 5 entries, flush_=0 for one cycle together with a retire request -> br_empty=1, br_commit_ stays 1, and next push gets br_tag=0.
REQ-026 Cycle 20 pushes and retires at DEPTH=8 -> pointers wrap, commits stay in order, and count never exceeds 8.
REQ-027 Assert reset for one cycle with 3 valid entries and a commit pulse pending -> next cycle br_commit_=1, br_empty=1, br_tag=0.
